// File: rtl/switch_event_pkg.sv
// Shared types and helpers for the switch change-event queue.
package switch_event_pkg;

  localparam int unsigned NUM_SWITCHES = 4;
  localparam int unsigned INDEX_W      = 2;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               level;
  } switch_event_t;

  // Lowest set bit wins, giving ascending-index event order.
  function automatic logic [INDEX_W-1:0] lowest_set(input logic [NUM_SWITCHES-1:0] v);
    logic [INDEX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SWITCHES - 1; i >= 0; i--) begin
      if (v[i]) idx = INDEX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_event_fifo.sv
// Single-clock FIFO with a registered head entry (no fall-through), push/pop at any fill level.
module switch_event_fifo #(
  parameter int unsigned Depth = 8,
  parameter type         data_t = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       async_rst_n,
  input  logic                       push,
  input  data_t                      push_data,
  input  logic                       pop,
  output data_t                      head,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  data_t          mem [Depth];
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [AW-1:0]  rd_next, wr_next;
  logic [CW-1:0]  count_q, count_next;
  data_t          head_q, head_next;
  logic           valid_q, full_q;
  logic           pop_ok, push_ok;

  // Head is pre-computed from the post-update read pointer so it can be registered.
  always_comb begin
    pop_ok     = pop & valid_q;
    push_ok    = push & (~full_q | pop_ok);
    rd_next    = rd_ptr_q + AW'(pop_ok);
    wr_next    = wr_ptr_q + AW'(push_ok);
    count_next = count_q + CW'(push_ok) - CW'(pop_ok);
    head_next  = (push_ok && (wr_ptr_q == rd_next)) ? push_data : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else if (push_ok || pop_ok) begin
      rd_ptr_q <= rd_next;
      wr_ptr_q <= wr_next;
      count_q  <= count_next;
      head_q   <= head_next;
      valid_q  <= (count_next != '0);
      full_q   <= (count_next == CW'(Depth));
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/switch_event_queue.sv
// Turns debounced switch levels into a FIFO of per-switch change events.
// Optional SWITCH_EVENT_TIMESTAMP_EN attaches a free-running timestamp to each event.
module switch_event_queue
  import switch_event_pkg::*;
#(
  parameter int unsigned Fifo_Depth      = 8,
  parameter int unsigned Timestamp_Width = 16
) (
  input  logic                          clk,
  input  logic                          async_rst_n,
  input  logic                          clk_en,
  input  logic [NUM_SWITCHES-1:0]       state_in,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [INDEX_W-1:0]            event_index,
  output logic                          event_level,
  output logic [Timestamp_Width-1:0]    event_timestamp,
  output logic [$clog2(Fifo_Depth):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

`ifdef SWITCH_EVENT_TIMESTAMP_EN
  typedef struct packed {
    logic [Timestamp_Width-1:0] ts;
    switch_event_t              ev;
  } entry_t;
`else
  typedef struct packed {
    switch_event_t ev;
  } entry_t;
`endif

  logic                      primed_q;
  logic [NUM_SWITCHES-1:0]   prev_state_q, pending_q, pend_level_q;
  logic                      overflow_q;

  logic [NUM_SWITCHES-1:0]   change, cand, cand_level, pending_next;
  logic [INDEX_W-1:0]        push_idx;
  logic                      push, pop, coalesce, fifo_full;
  entry_t                    push_entry, head;

`ifdef SWITCH_EVENT_TIMESTAMP_EN
  logic [Timestamp_Width-1:0] ts_q;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n)  ts_q <= '0;
    else if (clk_en)   ts_q <= ts_q + Timestamp_Width'(1);
  end
`endif

  // Change detect, pending merge and lowest-index selection.
  always_comb begin
    change       = '0;
    cand_level   = '0;
    push_entry   = '0;
    pop          = clk_en & event_valid & event_ready;
    if (primed_q) change = state_in ^ prev_state_q;
    cand = pending_q | change;
    for (int i = 0; i < NUM_SWITCHES; i++) begin
      cand_level[i] = change[i] ? state_in[i] : pend_level_q[i];
    end
    push_idx     = lowest_set(cand);
    push         = clk_en & primed_q & (|cand) & (~fifo_full | pop);
    coalesce     = clk_en & (|(change & pending_q));
    pending_next = push ? (cand & ~(NUM_SWITCHES'(1) << push_idx)) : cand;
    push_entry.ev.index = push_idx;
    push_entry.ev.level = cand_level[push_idx];
`ifdef SWITCH_EVENT_TIMESTAMP_EN
    push_entry.ts = ts_q;
`endif
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      primed_q     <= 1'b0;
      prev_state_q <= '0;
      pending_q    <= '0;
      pend_level_q <= '0;
      overflow_q   <= 1'b0;
    end else if (clk_en) begin
      primed_q     <= 1'b1;
      prev_state_q <= state_in;
      pending_q    <= pending_next;
      pend_level_q <= cand_level;
      if (coalesce)            overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  switch_event_fifo #(
    .Depth  (Fifo_Depth),
    .data_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .push        (push),
    .push_data   (push_entry),
    .pop         (pop),
    .head        (head),
    .valid       (event_valid),
    .full        (fifo_full),
    .count       (fifo_count)
  );

  assign event_index = head.ev.index;
  assign event_level = head.ev.level;
  assign overflow    = overflow_q;

`ifdef SWITCH_EVENT_TIMESTAMP_EN
  assign event_timestamp = head.ts;
`else
  assign event_timestamp = '0;
`endif

endmodule

// File: tb/tb_switch_event_queue.sv
// Directed bench for switch_event_queue with default parameters.
module tb_switch_event_queue;

  localparam int unsigned TW = 16;

  logic        clk = 1'b0;
  logic        async_rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [3:0]  state_in = '0;
  logic        event_valid;
  logic        event_ready = 1'b0;
  logic [1:0]  event_index;
  logic        event_level;
  logic [TW-1:0] event_timestamp;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  switch_event_queue #(.Fifo_Depth(8), .Timestamp_Width(TW)) dut (
    .clk             (clk),
    .async_rst_n     (async_rst_n),
    .clk_en          (clk_en),
    .state_in        (state_in),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_index     (event_index),
    .event_level     (event_level),
    .event_timestamp (event_timestamp),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .clear_overflow  (clear_overflow)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] st);
    async_rst_n    = 1'b0;
    clk_en         = 1'b1;
    event_ready    = 1'b0;
    clear_overflow = 1'b0;
    state_in       = st;
    tick();
    async_rst_n = 1'b1;
    tick();
  endtask

  // Eight single-bit toggles: sw0..3 rise, then sw0..3 fall; FIFO ends full.
  task automatic fill8();
    logic [3:0] st;
    st = state_in;
    for (int k = 0; k < 8; k++) begin
      st[k % 4] = ~st[k % 4];
      state_in = st;
      tick();
    end
  endtask

  task automatic test_reset();
    async_rst_n = 1'b0;
    state_in    = 4'b1010;
    clk_en      = 1'b1;
    event_ready = 1'b0;
    #1;
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0 ||
        event_index !== 2'd0 || event_level !== 1'b0 || event_timestamp !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b count=%0d ovf=%b idx=%0d lvl=%b ts=%0d, want all 0",
               event_valid, fifo_count, overflow, event_index, event_level, event_timestamp);
    end
    tick();
    async_rst_n = 1'b1;
    tick();
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_prime: valid=%b count=%0d, want 0 0", event_valid, fifo_count);
    end
    tick();
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_hold: valid=%b count=%0d, want 0 0", event_valid, fifo_count);
    end
  endtask

  task automatic test_single();
    do_reset(4'b0000);
    event_ready = 1'b1;
    state_in    = 4'b0100;
    tick();
    tests++;
    if (event_valid !== 1'b1 || event_index !== 2'd2 || event_level !== 1'b1 || fifo_count !== 4'd1) begin
      fails++;
      $display("FAIL single_event: valid=%b idx=%0d lvl=%b count=%0d, want 1 2 1 1",
               event_valid, event_index, event_level, fifo_count);
    end
    tick();
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL single_popped: valid=%b count=%0d ovf=%b, want 0 0 0",
               event_valid, fifo_count, overflow);
    end
  endtask

  task automatic test_multi();
    logic [1:0] exp_idx [3];
    exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd3;
    do_reset(4'b0000);
    state_in = 4'b1011;
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (fifo_count !== 4'(k) || event_index !== 2'd0 || event_level !== 1'b1) begin
        fails++;
        $display("FAIL multi_push%0d: count=%0d head_idx=%0d lvl=%b, want %0d 0 1",
                 k, fifo_count, event_index, event_level, k);
      end
    end
    tick();
    tests++;
    if (fifo_count !== 4'd3) begin
      fails++;
      $display("FAIL multi_settle: count=%0d, want 3", fifo_count);
    end
    event_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (event_valid !== 1'b1 || event_index !== exp_idx[k] || event_level !== 1'b1) begin
        fails++;
        $display("FAIL multi_order%0d: valid=%b idx=%0d lvl=%b, want 1 %0d 1",
                 k, event_valid, event_index, event_level, exp_idx[k]);
      end
      tick();
    end
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL multi_empty: valid=%b count=%0d, want 0 0", event_valid, fifo_count);
    end
  endtask

  task automatic test_full();
    logic [1:0] exp_idx [10];
    logic       exp_lvl [10];
    for (int k = 0; k < 8; k++) begin
      exp_idx[k] = 2'(k % 4);
      exp_lvl[k] = (k < 4);
    end
    exp_idx[8] = 2'd0; exp_lvl[8] = 1'b1;
    exp_idx[9] = 2'd1; exp_lvl[9] = 1'b1;
    do_reset(4'b0000);
    fill8();
    tests++;
    if (fifo_count !== 4'd8) begin
      fails++;
      $display("FAIL full_count8: count=%0d, want 8", fifo_count);
    end
    state_in = 4'b0001;
    tick();
    state_in = 4'b0011;
    tick();
    tests++;
    if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_pending: count=%0d ovf=%b, want 8 0", fifo_count, overflow);
    end
    event_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (event_valid !== 1'b1 || event_index !== exp_idx[k] || event_level !== exp_lvl[k]) begin
        fails++;
        $display("FAIL full_drain%0d: valid=%b idx=%0d lvl=%b, want 1 %0d %b",
                 k, event_valid, event_index, event_level, exp_idx[k], exp_lvl[k]);
      end
      tick();
      if (k < 2) begin
        tests++;
        if (fifo_count !== 4'd8) begin
          fails++;
          $display("FAIL full_pushpop%0d: count=%0d, want 8", k, fifo_count);
        end
      end
    end
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_empty: valid=%b count=%0d ovf=%b, want 0 0 0",
               event_valid, fifo_count, overflow);
    end
  endtask

  task automatic test_coalesce();
    logic [1:0] exp_idx [9];
    logic       exp_lvl [9];
    for (int k = 0; k < 8; k++) begin
      exp_idx[k] = 2'(k % 4);
      exp_lvl[k] = (k < 4);
    end
    exp_idx[8] = 2'd1; exp_lvl[8] = 1'b0;
    do_reset(4'b0000);
    fill8();
    state_in = 4'b0010;
    tick();
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL coal_first: ovf=%b, want 0", overflow);
    end
    state_in = 4'b0000;
    tick();
    tests++;
    if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
      fails++;
      $display("FAIL coal_set: ovf=%b count=%0d, want 1 8", overflow, fifo_count);
    end
    event_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tests++;
      if (event_valid !== 1'b1 || event_index !== exp_idx[k] || event_level !== exp_lvl[k]) begin
        fails++;
        $display("FAIL coal_drain%0d: valid=%b idx=%0d lvl=%b, want 1 %0d %b",
                 k, event_valid, event_index, event_level, exp_idx[k], exp_lvl[k]);
      end
      tick();
    end
    tests++;
    if (event_valid !== 1'b0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL coal_sticky: valid=%b ovf=%b, want 0 1", event_valid, overflow);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL coal_clear: ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_clk_en_and_reset();
    do_reset(4'b0000);
    clk_en      = 1'b0;
    event_ready = 1'b1;
    state_in    = 4'b0001;
    repeat (5) tick();
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL clken_gated: valid=%b count=%0d, want 0 0", event_valid, fifo_count);
    end
    clk_en = 1'b1;
    tick();
    tests++;
    if (event_valid !== 1'b1 || event_index !== 2'd0 || event_level !== 1'b1 || fifo_count !== 4'd1) begin
      fails++;
      $display("FAIL clken_event: valid=%b idx=%0d lvl=%b count=%0d, want 1 0 1 1",
               event_valid, event_index, event_level, fifo_count);
    end
    event_ready = 1'b0;
    state_in    = 4'b0111;
    tick();
    tick();
    tests++;
    if (fifo_count !== 4'd3) begin
      fails++;
      $display("FAIL clken_fill: count=%0d, want 3", fifo_count);
    end
    event_ready = 1'b1;
    tick();
    tests++;
    if (fifo_count !== 4'd2 || event_index !== 2'd1) begin
      fails++;
      $display("FAIL clken_pop: count=%0d idx=%0d, want 2 1", fifo_count, event_index);
    end
    #2;
    async_rst_n = 1'b0;
    #1;
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%b count=%0d, want 0 0", event_valid, fifo_count);
    end
    @(negedge clk);
    async_rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if (event_valid !== 1'b0 || fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_prime: valid=%b count=%0d, want 0 0", event_valid, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_full();
    test_coalesce();
    test_clk_en_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
